// File: rtl/decode_stage.sv
// Decode stage: splits 16-bit instructions into fields and control flags. It also
// handles load-use bubbles, halt, branch flush and fetch back-pressure through a one-entry skid.
module decode_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] inst,
  input  logic              inst_valid,
  input  logic              flush,
  output logic              fetch_stall,
  input  logic              ex_ready,
  output logic              dec_valid,
  output logic [DATA_W-1:0] dec_pc,
  output logic [3:0]        dec_op,
  output logic [REG_AW-1:0] dec_rd,
  output logic [REG_AW-1:0] dec_rs,
  output logic [REG_AW-1:0] dec_rt,
  output logic [DATA_W-1:0] dec_imm,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              is_branch,
  output logic              is_halt
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_BUBBLE = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam logic [3:0] OP_LW   = 4'h9;
  localparam logic [3:0] OP_LUI  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Flag order: {reg_write, mem_read, mem_write, is_branch, is_halt}
  function automatic logic [4:0] ctrl_flags(input logic [3:0] op, input logic [REG_AW-1:0] rd);
    logic [4:0] f;
    f = 5'b00000;
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hE: f = 5'b10000;
      4'h9:                                               f = 5'b11000;
      4'hA:                                               f = 5'b00100;
      4'hB, 4'hC, 4'hD:                                   f = 5'b00010;
      4'hF:                                               f = 5'b00001;
      default:                                            f = 5'b00000;
    endcase
    if (rd == {REG_AW{1'b0}}) begin
      f[4] = 1'b0;
    end else begin
      f[4] = f[4];
    end
    return f;
  endfunction

  function automatic logic [DATA_W-1:0] make_imm(input logic [3:0] op, input logic [7:0] lo);
    if (op == OP_LUI) begin
      return {lo, {(DATA_W-8){1'b0}}};
    end else begin
      return {{(DATA_W-8){lo[7]}}, lo};
    end
  endfunction

  // True when the instruction reads register r as a source operand.
  function automatic logic reads_reg(input logic [3:0] op, input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                                     input logic [REG_AW-1:0] r);
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hB, 4'hC: return (rs == r) || (rt == r);
      4'h8, 4'h9:                                           return (rs == r);
      4'hA:                                                 return (rs == r) || (rd == r);
      default:                                              return 1'b0;
    endcase
  endfunction

  logic [1:0]        state_r;
  logic              skid_valid_r;
  logic [DATA_W-1:0] skid_pc_r;
  logic [DATA_W-1:0] skid_inst_r;
  logic              ll_valid_r;
  logic [REG_AW-1:0] ll_rd_r;

  logic              take_in_s;
  logic              cand_valid_s;
  logic [DATA_W-1:0] cand_pc_s;
  logic [DATA_W-1:0] cand_inst_s;
  logic              load_s;
  logic              halt_acc_s;
  logic              hazard_s;
  logic              issue_s;
  logic              clear_out_s;
  logic [1:0]        nxt_state_s;
  logic              nxt_skid_valid_s;
  logic [DATA_W-1:0] nxt_skid_pc_s;
  logic [DATA_W-1:0] nxt_skid_inst_s;
  logic              nxt_ll_valid_s;
  logic [REG_AW-1:0] nxt_ll_rd_s;

  // Candidate selection, hazard detection and next-state computation.
  always_comb begin
    take_in_s    = inst_valid && !fetch_stall;
    cand_valid_s = skid_valid_r || take_in_s;
    cand_pc_s    = skid_valid_r ? skid_pc_r   : pc;
    cand_inst_s  = skid_valid_r ? skid_inst_r : inst;
    load_s       = !dec_valid || ex_ready;
    halt_acc_s   = dec_valid && ex_ready && (dec_op == OP_HALT);
    hazard_s     = ll_valid_r && cand_valid_s &&
                   reads_reg(cand_inst_s[15:12], cand_inst_s[11:8], cand_inst_s[7:4],
                             cand_inst_s[3:0], ll_rd_r);

    issue_s          = 1'b0;
    clear_out_s      = 1'b0;
    nxt_state_s      = state_r;
    nxt_skid_valid_s = skid_valid_r;
    nxt_skid_pc_s    = skid_pc_r;
    nxt_skid_inst_s  = skid_inst_r;
    nxt_ll_valid_s   = ll_valid_r;
    nxt_ll_rd_s      = ll_rd_r;

    if (flush) begin
      clear_out_s      = 1'b1;
      nxt_skid_valid_s = 1'b0;
      nxt_ll_valid_s   = 1'b0;
      nxt_state_s      = ST_RUN;
    end else if (state_r == ST_HALTED) begin
      clear_out_s = 1'b1;
    end else if (halt_acc_s) begin
      clear_out_s = 1'b1;
      nxt_state_s = ST_HALTED;
    end else if (load_s) begin
      nxt_state_s = ST_RUN;
      if (!cand_valid_s) begin
        clear_out_s = 1'b1;
      end else if (hazard_s) begin
        // Park the dependent instruction in the skid and emit one empty slot.
        clear_out_s      = 1'b1;
        nxt_state_s      = ST_BUBBLE;
        nxt_ll_valid_s   = 1'b0;
        nxt_skid_valid_s = 1'b1;
        nxt_skid_pc_s    = cand_pc_s;
        nxt_skid_inst_s  = cand_inst_s;
      end else begin
        issue_s        = 1'b1;
        nxt_ll_valid_s = (cand_inst_s[15:12] == OP_LW) && (cand_inst_s[11:8] != 4'h0);
        nxt_ll_rd_s    = cand_inst_s[11:8];
        if (skid_valid_r && take_in_s) begin
          nxt_skid_pc_s   = pc;
          nxt_skid_inst_s = inst;
        end else begin
          nxt_skid_valid_s = 1'b0;
        end
      end
    end else begin
      if (take_in_s) begin
        nxt_skid_valid_s = 1'b1;
        nxt_skid_pc_s    = pc;
        nxt_skid_inst_s  = inst;
      end else begin
        nxt_skid_valid_s = skid_valid_r;
      end
    end
  end

  // Control state, skid entry and load tracker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_RUN;
      skid_valid_r <= 1'b0;
      skid_pc_r    <= {DATA_W{1'b0}};
      skid_inst_r  <= {DATA_W{1'b0}};
      ll_valid_r   <= 1'b0;
      ll_rd_r      <= {REG_AW{1'b0}};
      fetch_stall  <= 1'b0;
    end else begin
      state_r      <= nxt_state_s;
      skid_valid_r <= nxt_skid_valid_s;
      skid_pc_r    <= nxt_skid_pc_s;
      skid_inst_r  <= nxt_skid_inst_s;
      ll_valid_r   <= nxt_ll_valid_s;
      ll_rd_r      <= nxt_ll_rd_s;
      fetch_stall  <= nxt_skid_valid_s || (nxt_state_s == ST_HALTED);
    end
  end

  // Output register toward execute: load decoded candidate, clear, or hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_valid <= 1'b0;
      dec_pc    <= {DATA_W{1'b0}};
      dec_op    <= 4'h0;
      dec_rd    <= {REG_AW{1'b0}};
      dec_rs    <= {REG_AW{1'b0}};
      dec_rt    <= {REG_AW{1'b0}};
      dec_imm   <= {DATA_W{1'b0}};
      {reg_write, mem_read, mem_write, is_branch, is_halt} <= 5'b00000;
    end else if (issue_s) begin
      dec_valid <= 1'b1;
      dec_pc    <= cand_pc_s;
      dec_op    <= cand_inst_s[15:12];
      dec_rd    <= cand_inst_s[11:8];
      dec_rs    <= cand_inst_s[7:4];
      dec_rt    <= cand_inst_s[3:0];
      dec_imm   <= make_imm(cand_inst_s[15:12], cand_inst_s[7:0]);
      {reg_write, mem_read, mem_write, is_branch, is_halt} <=
        ctrl_flags(cand_inst_s[15:12], cand_inst_s[11:8]);
    end else if (clear_out_s) begin
      dec_valid <= 1'b0;
      dec_pc    <= {DATA_W{1'b0}};
      dec_op    <= 4'h0;
      dec_rd    <= {REG_AW{1'b0}};
      dec_rs    <= {REG_AW{1'b0}};
      dec_rt    <= {REG_AW{1'b0}};
      dec_imm   <= {DATA_W{1'b0}};
      {reg_write, mem_read, mem_write, is_branch, is_halt} <= 5'b00000;
    end else begin
      dec_valid <= dec_valid;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instructions push hand-computed
// expectations; a negedge monitor pops and compares every accepted output.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc;
  logic [15:0] inst;
  logic        inst_valid;
  logic        flush;
  logic        fetch_stall;
  logic        ex_ready;
  logic        dec_valid;
  logic [15:0] dec_pc;
  logic [3:0]  dec_op;
  logic [3:0]  dec_rd;
  logic [3:0]  dec_rs;
  logic [3:0]  dec_rt;
  logic [15:0] dec_imm;
  logic        reg_write, mem_read, mem_write, is_branch, is_halt;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] inst;
    logic [15:0] imm;
    logic [4:0]  flags;
  } exp_t;

  exp_t expq[$];
  int checks = 0;
  int errors = 0;

  decode_stage dut (
    .clk(clk), .rst(rst), .pc(pc), .inst(inst), .inst_valid(inst_valid),
    .flush(flush), .fetch_stall(fetch_stall), .ex_ready(ex_ready),
    .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_op(dec_op), .dec_rd(dec_rd),
    .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_imm(dec_imm), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .is_branch(is_branch), .is_halt(is_halt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshake pops one expectation.
  always @(negedge clk) begin
    if (!rst && dec_valid && ex_ready) begin
      if (expq.size() == 0) begin
        chk("unexpected_issue", {16'h0, dec_pc}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("sb_pc", {16'h0, dec_pc}, {16'h0, e.pc});
        chk("sb_fields", {16'h0, dec_op, dec_rd, dec_rs, dec_rt}, {16'h0, e.inst});
        chk("sb_imm", {16'h0, dec_imm}, {16'h0, e.imm});
        chk("sb_flags", {27'h0, reg_write, mem_read, mem_write, is_branch, is_halt},
            {27'h0, e.flags});
      end
    end
  end

  // flags: {reg_write, mem_read, mem_write, is_branch, is_halt}
  task automatic send(input logic [15:0] p, input logic [15:0] i,
                      input logic [15:0] e_imm, input logic [4:0] e_flags);
    exp_t e;
    logic stalled;
    logic done;
    e.pc = p; e.inst = i; e.imm = e_imm; e.flags = e_flags;
    expq.push_back(e);
    pc = p; inst = i; inst_valid = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 50; n++) begin
      stalled = fetch_stall;
      @(posedge clk); #1;
      if (!stalled) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("send_timeout", 32'h0, 32'h1);
  endtask

  task automatic idle(input int n);
    inst_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ex_ready = 1'b0; inst_valid = 1'b0; flush = 1'b0; pc = 16'h0; inst = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'h0, dec_valid}, 32'h0);
    chk("rst_stall", {31'h0, fetch_stall}, 32'h0);
    chk("rst_pc_imm", {dec_pc, dec_imm}, 32'h0);
    chk("rst_flags", {27'h0, reg_write, mem_read, mem_write, is_branch, is_halt}, 32'h0);
    rst = 1'b0; ex_ready = 1'b1;

    // Basic stream, one-cycle latency, immediates and rd==0 write suppression
    send(16'h0000, 16'h1123, 16'h0023, 5'b10000);
    chk("lat0_valid", {31'h0, dec_valid}, 32'h1);
    chk("lat0_pc", {16'h0, dec_pc}, 32'h0);
    send(16'h0001, 16'h8205, 16'h0005, 5'b10000);
    chk("lat1_pc", {16'h0, dec_pc}, 32'h1);
    send(16'h0002, 16'h83F0, 16'hFFF0, 5'b10000);
    send(16'h0003, 16'hE412, 16'h1200, 5'b10000);
    send(16'h0004, 16'h1045, 16'h0045, 5'b00000);
    idle(2);

    // Load-use bubble
    send(16'h0010, 16'h9120, 16'h0020, 5'b11000);
    send(16'h0011, 16'h1314, 16'h0014, 5'b10000);
    chk("lu_bubble", {31'h0, dec_valid}, 32'h0);
    chk("lu_stall", {31'h0, fetch_stall}, 32'h1);
    idle(1);
    chk("lu_issue", {15'h0, dec_valid, dec_pc}, {15'h0, 1'b1, 16'h0011});
    chk("lu_stall_clr", {31'h0, fetch_stall}, 32'h0);
    idle(2);

    // Back-pressure for three cycles during a five-instruction stream
    send(16'h0020, 16'h2123, 16'h0023, 5'b10000);
    ex_ready = 1'b0;
    fork
      begin
        send(16'h0021, 16'h3456, 16'h0056, 5'b10000);
        send(16'h0022, 16'hA7F8, 16'hFFF8, 5'b00100);
        send(16'h0023, 16'hB9AB, 16'hFFAB, 5'b00010);
        send(16'h0024, 16'hD0C0, 16'hFFC0, 5'b00010);
      end
      begin
        for (int k = 0; k < 3; k++) begin
          @(posedge clk); #1;
          chk("bp_hold_pc", {15'h0, dec_valid, dec_pc}, {15'h0, 1'b1, 16'h0020});
          chk("bp_stall", {31'h0, fetch_stall}, 32'h1);
        end
        ex_ready = 1'b1;
      end
    join
    idle(4);

    // Flush with skid full and execute stalled
    ex_ready = 1'b0;
    send(16'h0030, 16'h4111, 16'h0011, 5'b10000);
    send(16'h0031, 16'h5222, 16'h0022, 5'b10000);
    chk("fl_pre_stall", {31'h0, fetch_stall}, 32'h1);
    pc = 16'h0032; inst = 16'h6333; inst_valid = 1'b1; flush = 1'b1;
    expq.delete();
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fl_valid", {31'h0, dec_valid}, 32'h0);
    chk("fl_stall", {31'h0, fetch_stall}, 32'h0);
    ex_ready = 1'b1;
    send(16'h0040, 16'h7444, 16'h0044, 5'b10000);
    chk("fl_new_issue", {15'h0, dec_valid, dec_pc}, {15'h0, 1'b1, 16'h0040});
    idle(2);

    // Halt, held for ten cycles, released by flush
    send(16'h0050, 16'hF000, 16'h0000, 5'b00001);
    inst_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("halt_hold", {30'h0, dec_valid, fetch_stall}, 32'h1);
      if (k == 0) begin
        pc = 16'h0051; inst = 16'h1111; inst_valid = 1'b1;
      end
    end
    inst_valid = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("halt_exit", {30'h0, dec_valid, fetch_stall}, 32'h0);
    send(16'h0060, 16'h1567, 16'h0067, 5'b10000);
    chk("halt_resume", {15'h0, dec_valid, dec_pc}, {15'h0, 1'b1, 16'h0060});
    idle(3);
    chk("queue_drained", expq.size(), 32'h0);

    // Asynchronous reset in mid-stream
    send(16'h0070, 16'h1234, 16'h0034, 5'b10000);
    send(16'h0071, 16'h2345, 16'h0045, 5'b10000);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid_stall", {30'h0, dec_valid, fetch_stall}, 32'h0);
    chk("arst_pc_imm", {dec_pc, dec_imm}, 32'h0);
    chk("arst_flags", {27'h0, reg_write, mem_read, mem_write, is_branch, is_halt}, 32'h0);
    expq.delete();
    inst_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
